// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI initiator for the register-access slave protocol.
// One frame per accepted command: RW, ADDR (LSB-first), turnaround, DATA (LSB-first).
// SCK is a registered, divided copy of Clk; everything lives in the Clk domain.
//
// Handshake: a command transfers on a Clk edge where CmdValid && CmdReady are both
// high. CmdReady is only ever high in IDLE, so CmdValid outside IDLE has no effect.
// RspValid is a single-cycle pulse with no back-pressure; RspRData holds its value
// until the next pulse.
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 4
) (
    input  logic                  Clk,
    input  logic                  aRst_n,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic                  CmdRW,
    input  logic [ADDR_WIDTH-1:0] CmdAddr,
    input  logic [DATA_WIDTH-1:0] CmdWData,
    output logic                  RspValid,
    output logic [DATA_WIDTH-1:0] RspRData,
    output logic                  Busy,
    output logic                  CS,
    output logic                  SCK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [2:0]            DbgState
);

    // Slots per frame: RW + address + turnaround + data.
    localparam int N       = ADDR_WIDTH + DATA_WIDTH + 2;
    localparam int SLOT_W  = $clog2(N + 1);
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(CS_GAP - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(N - 1);
    localparam logic [SLOT_W-1:0] DATA_FIRST = SLOT_W'(ADDR_WIDTH + 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TAIL  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      div_cnt;   // Clk cycles spent in the current phase
    logic [SLOT_W-1:0]     slot_cnt;  // current frame slot
    logic [N-1:0]          tx_sr;     // bit 0 is the slot currently on MOSI
    logic [DATA_WIDTH-1:0] rx_sr;     // read data, filled from the MSB end
    logic                  rw_q;

    assign DbgState = state;

    // Frame sequencer: all pad outputs and handshake signals are registered here.
    always_ff @(posedge Clk or negedge aRst_n) begin
        if (!aRst_n) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            slot_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rw_q     <= 1'b0;
            CmdReady <= 1'b0;
            RspValid <= 1'b0;
            RspRData <= '0;
            Busy     <= 1'b0;
            CS       <= 1'b1;
            SCK      <= 1'b1;
            MOSI     <= 1'b0;
        end else begin
            RspValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (CmdReady && CmdValid) begin
                        // Data slots of a read drive 0, so mask write data by RW.
                        rw_q     <= CmdRW;
                        tx_sr    <= {CmdWData & {DATA_WIDTH{CmdRW}}, 1'b0, CmdAddr, CmdRW};
                        MOSI     <= CmdRW;
                        CmdReady <= 1'b0;
                        Busy     <= 1'b1;
                        CS       <= 1'b0;
                        div_cnt  <= '0;
                        state    <= S_LEAD;
                    end else begin
                        CmdReady <= 1'b1;
                    end
                end

                S_LEAD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        slot_cnt <= '0;
                        SCK      <= 1'b0;
                        state    <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!SCK) begin
                            // Rising edge: slave samples MOSI, we sample MISO.
                            SCK <= 1'b1;
                            if (!rw_q && (slot_cnt >= DATA_FIRST)) begin
                                rx_sr <= {MISO, rx_sr[DATA_WIDTH-1:1]};
                            end
                        end else if (slot_cnt == SLOT_LAST) begin
                            // SCK stays high into the tail.
                            state <= S_TAIL;
                        end else begin
                            // Falling edge starts the next slot; MOSI moves only here.
                            SCK      <= 1'b0;
                            slot_cnt <= slot_cnt + 1'b1;
                            tx_sr    <= tx_sr >> 1;
                            MOSI     <= tx_sr[1];
                        end
                    end
                end

                S_TAIL: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        CS       <= 1'b1;
                        MOSI     <= 1'b0;
                        RspValid <= 1'b1;
                        RspRData <= rw_q ? '0 : rx_sr;
                        state    <= S_GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt  <= '0;
                        Busy     <= 1'b0;
                        CmdReady <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
